// File: rtl/param_code_lock.sv
// Parameterised keypad code lock with retry limit, error display, auto-relock and lockout.
// Optional feature: define CODE_PROG_EN to allow reprogramming the code while unlocked.
module param_code_lock #(
    parameter int CODE_LEN       = 4,
    parameter int DIGIT_W        = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0] CODE = 16'h1234,
    parameter int MAX_TRIES      = 3,
    parameter int ERR_CYCLES     = 8,
    parameter int UNLOCK_CYCLES  = 256,
    parameter int LOCKOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DIGIT_W-1:0] in_digit,
    input  logic               enter_btn,
    input  logic               prog_btn,
    output logic               locked_led,
    output logic               unlocked_led,
    output logic               error_led,
    output logic               lockout_led,
    output logic [2:0]         state_leds
);

    localparam int CNT_W   = $clog2(CODE_LEN + 1);
    localparam int FAIL_W  = $clog2(MAX_TRIES + 1);
    localparam int TMR_MX1 = (ERR_CYCLES > UNLOCK_CYCLES) ? ERR_CYCLES : UNLOCK_CYCLES;
    localparam int TMR_MAX = (TMR_MX1 > LOCKOUT_CYCLES) ? TMR_MX1 : LOCKOUT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        S_LOCKED   = 3'd0,
        S_ENTRY    = 3'd1,
        S_CHECK    = 3'd2,
        S_ERROR    = 3'd3,
        S_UNLOCKED = 3'd4,
        S_LOCKOUT  = 3'd5,
        S_PROGRAM  = 3'd6
    } state_t;

    state_t                               r_state;
    logic [0:CODE_LEN-1][DIGIT_W-1:0]     r_buf;
    logic [CNT_W-1:0]                     r_count;
    logic [TMR_W-1:0]                     r_timer;
    logic [FAIL_W-1:0]                    r_fail;
    logic                                 r_enter_prev;

    logic                                 w_press;
    logic                                 w_last;
    logic                                 w_match;
    logic [FAIL_W-1:0]                    w_fail_inc;
    logic [0:CODE_LEN-1][DIGIT_W-1:0]     w_buf_ins;
    logic [CODE_LEN*DIGIT_W-1:0]          w_active_code;

    assign w_press    = enter_btn & ~r_enter_prev;
    assign w_last     = (r_count == CNT_W'(CODE_LEN - 1));
    assign w_match    = (r_buf == w_active_code);
    assign w_fail_inc = r_fail + 1'b1;

    // Buffer element 0 is the first digit entered, which lands in the MS digit.
    always_comb begin
        w_buf_ins = r_buf;
        for (int k = 0; k < CODE_LEN; k++) begin
            if (r_count == CNT_W'(k)) w_buf_ins[k] = in_digit;
        end
    end

`ifdef CODE_PROG_EN
    logic [CODE_LEN*DIGIT_W-1:0] r_code;
    assign w_active_code = r_code;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_code <= CODE;
        end else if (r_state == S_PROGRAM && w_press && w_last) begin
            r_code <= w_buf_ins;
        end
    end
`else
    logic w_unused_prog;
    assign w_active_code = CODE;
    assign w_unused_prog = prog_btn;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_LOCKED;
            r_buf        <= '0;
            r_count      <= '0;
            r_timer      <= '0;
            r_fail       <= '0;
            r_enter_prev <= 1'b1;
        end else begin
            r_enter_prev <= enter_btn;
            if (r_timer != {TMR_W{1'b1}}) r_timer <= r_timer + 1'b1;

            case (r_state)
                S_LOCKED: begin
                    if (w_press) begin
                        r_buf   <= w_buf_ins;
                        r_timer <= '0;
                        if (CODE_LEN == 1) begin
                            r_count <= '0;
                            r_state <= S_CHECK;
                        end else begin
                            r_count <= CNT_W'(1);
                            r_state <= S_ENTRY;
                        end
                    end
                end
                S_ENTRY: begin
                    if (w_press) begin
                        r_buf <= w_buf_ins;
                        if (w_last) begin
                            r_count <= '0;
                            r_timer <= '0;
                            r_state <= S_CHECK;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    r_count <= '0;
                    r_timer <= '0;
                    if (w_match) begin
                        r_fail  <= '0;
                        r_state <= S_UNLOCKED;
                    end else begin
                        r_fail  <= w_fail_inc;
                        r_state <= (w_fail_inc == FAIL_W'(MAX_TRIES)) ? S_LOCKOUT : S_ERROR;
                    end
                end
                S_ERROR: begin
                    if (r_timer == TMR_W'(ERR_CYCLES - 1)) begin
                        r_count <= '0;
                        r_timer <= '0;
                        r_state <= S_LOCKED;
                    end
                end
                S_UNLOCKED: begin
                    if (w_press || r_timer == TMR_W'(UNLOCK_CYCLES - 1)) begin
                        r_count <= '0;
                        r_timer <= '0;
                        r_state <= S_LOCKED;
                    end
`ifdef CODE_PROG_EN
                    else if (prog_btn) begin
                        r_count <= '0;
                        r_timer <= '0;
                        r_state <= S_PROGRAM;
                    end
`endif
                end
                S_LOCKOUT: begin
                    if (r_timer == TMR_W'(LOCKOUT_CYCLES - 1)) begin
                        r_fail  <= '0;
                        r_count <= '0;
                        r_timer <= '0;
                        r_state <= S_LOCKED;
                    end
                end
`ifdef CODE_PROG_EN
                S_PROGRAM: begin
                    if (w_press) begin
                        r_buf <= w_buf_ins;
                        if (w_last) begin
                            r_count <= '0;
                            r_timer <= '0;
                            r_state <= S_LOCKED;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    r_count <= '0;
                    r_timer <= '0;
                    r_state <= S_LOCKED;
                end
            endcase
        end
    end

    assign locked_led   = (r_state != S_UNLOCKED);
    assign unlocked_led = (r_state == S_UNLOCKED);
    assign error_led    = (r_state == S_ERROR) || (r_state == S_LOCKOUT);
    assign lockout_led  = (r_state == S_LOCKOUT);
    assign state_leds   = r_state;

endmodule

// File: tb/tb_param_code_lock.sv
// Bench for param_code_lock: directed scenarios plus random code entry against a cycle model.
module tb_param_code_lock;

    localparam int ERR_N  = 8;
    localparam int UNL_N  = 256;
    localparam int LCK_N  = 1024;
    localparam int TRIES  = 3;
    localparam int NDIG   = 4;

    logic       clk;
    logic       reset;
    logic [3:0] in_digit;
    logic       enter_btn;
    logic       prog_btn;
    logic       locked_led, unlocked_led, error_led, lockout_led;
    logic [2:0] state_leds;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    param_code_lock dut (
        .clk          (clk),
        .reset        (reset),
        .in_digit     (in_digit),
        .enter_btn    (enter_btn),
        .prog_btn     (prog_btn),
        .locked_led   (locked_led),
        .unlocked_led (unlocked_led),
        .error_led    (error_led),
        .lockout_led  (lockout_led),
        .state_leds   (state_leds)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode numbers follow the published state encodings, digits kept in a queue.
    int         m_state, m_dwell, m_fail, nxt;
    bit         m_prev, press, ok;
    logic [3:0] m_q[$];
    logic [3:0] m_code[NDIG];
    logic [15:0] factory = 16'h1234;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state = 0; m_dwell = 0; m_fail = 0; m_prev = 1;
            m_q.delete();
            for (int i = 0; i < NDIG; i++) m_code[i] = factory[(NDIG-1-i)*4 +: 4];
        end else begin
            press  = enter_btn && !m_prev;
            m_prev = enter_btn;
            nxt    = m_state;
            case (m_state)
                0: if (press) begin
                       m_q.delete();
                       m_q.push_back(in_digit);
                       nxt = (NDIG == 1) ? 2 : 1;
                   end
                1: if (press) begin
                       m_q.push_back(in_digit);
                       if (m_q.size() == NDIG) nxt = 2;
                   end
                2: begin
                       ok = (m_q.size() == NDIG);
                       for (int i = 0; i < m_q.size() && i < NDIG; i++)
                           if (m_q[i] != m_code[i]) ok = 0;
                       if (ok) begin m_fail = 0; nxt = 4; end
                       else begin m_fail++; nxt = (m_fail == TRIES) ? 5 : 3; end
                   end
                3: begin m_dwell++; if (m_dwell >= ERR_N) nxt = 0; end
                4: begin
                       if (press) nxt = 0;
                       else begin
                           m_dwell++;
                           if (m_dwell >= UNL_N) nxt = 0;
`ifdef CODE_PROG_EN
                           else if (prog_btn) begin nxt = 6; m_q.delete(); end
`endif
                       end
                   end
                5: begin
                       m_dwell++;
                       if (m_dwell >= LCK_N) begin nxt = 0; m_fail = 0; end
                   end
                6: if (press) begin
                       m_q.push_back(in_digit);
                       if (m_q.size() == NDIG) begin
                           for (int i = 0; i < NDIG; i++) m_code[i] = m_q[i];
                           nxt = 0;
                       end
                   end
                default: nxt = 0;
            endcase
            if (nxt != m_state) m_dwell = 0;
            m_state = nxt;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("state",    32'(state_leds),   32'(m_state));
            check("locked",   32'(locked_led),   32'(m_state != 4));
            check("unlocked", 32'(unlocked_led), 32'(m_state == 4));
            check("error",    32'(error_led),    32'(m_state == 3 || m_state == 5));
            check("lockout",  32'(lockout_led),  32'(m_state == 5));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic press_digit(input logic [3:0] d, input int gap);
        in_digit  = d;
        enter_btn = 1'b1;
        tick(1);
        enter_btn = 1'b0;
        tick(1 + gap);
    endtask

    task automatic enter_code(input logic [15:0] c);
        for (int i = 0; i < NDIG; i++) press_digit(c[(NDIG-1-i)*4 +: 4], $urandom_range(0, 2));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"},    32'(state_leds),   32'd0);
        check({tag, "_locked"},   32'(locked_led),   32'd1);
        check({tag, "_unlocked"}, 32'(unlocked_led), 32'd0);
        check({tag, "_error"},    32'(error_led),    32'd0);
        check({tag, "_lockout"},  32'(lockout_led),  32'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    logic [15:0] code_w;

    initial begin
        reset = 1'b0; in_digit = '0; enter_btn = 1'b0; prog_btn = 1'b0;
        #1 reset = 1'b1;
        #1 check_reset_outputs("rst");
        chk_en = 1;
        tick(3);
        reset = 1'b0;
        tick(2);

        // Correct code unlocks, then auto-relock after the timeout.
        enter_code(16'h1234);
        check("unlock_state", 32'(state_leds), 32'd4);
        check("unlock_led",   32'(unlocked_led), 32'd1);
        tick(UNL_N);
        check("relock_led",   32'(locked_led), 32'd1);

        // Wrong code shows error, presses ignored during display.
        enter_code(16'h1235);
        check("err_state", 32'(state_leds), 32'd3);
        check("err_led",   32'(error_led), 32'd1);
        press_digit(4'h7, 0);
        press_digit(4'h7, 0);
        tick(ERR_N + 2);
        check("err_done", 32'(state_leds), 32'd0);

        // Three consecutive failures lock out; correct code ignored meanwhile.
        pulse_reset();
        for (int t = 0; t < TRIES; t++) begin
            enter_code(16'h4321);
            if (t < TRIES - 1) tick(ERR_N + 2);
        end
        check("lko_state", 32'(state_leds), 32'd5);
        check("lko_led",   32'(lockout_led), 32'd1);
        enter_code(16'h1234);
        check("lko_ignore", 32'(state_leds), 32'd5);
        tick(LCK_N + 4);
        check("lko_done", 32'(state_leds), 32'd0);
        enter_code(16'h9999);
        check("fail_cleared", 32'(state_leds), 32'd3);
        tick(ERR_N + 2);

        // Held button yields one digit; reset mid-entry aborts.
        in_digit = 4'h1; enter_btn = 1'b1;
        tick(50);
        enter_btn = 1'b0;
        tick(2);
        check("held_entry", 32'(state_leds), 32'd1);
        press_digit(4'h2, 1);
        reset = 1'b1;
        #1 check_reset_outputs("midrst");
        tick(2);
        reset = 1'b0;
        tick(2);
        enter_code(16'h1234);
        check("post_rst_unlock", 32'(state_leds), 32'd4);
        press_digit(4'h0, 1);
        check("manual_relock", 32'(state_leds), 32'd0);

        // Button held through reset must not register a press.
        enter_btn = 1'b1;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(3);
        enter_btn = 1'b0;
        tick(2);
        check("held_thru_rst", 32'(state_leds), 32'd0);

`ifdef CODE_PROG_EN
        enter_code(16'h1234);
        prog_btn = 1'b1;
        tick(1);
        prog_btn = 1'b0;
        check("prog_enter", 32'(state_leds), 32'd6);
        enter_code(16'h9876);
        check("prog_done", 32'(state_leds), 32'd0);
        enter_code(16'h1234);
        check("old_code_fails", 32'(state_leds), 32'd3);
        tick(ERR_N + 2);
        enter_code(16'h9876);
        check("new_code_unlocks", 32'(state_leds), 32'd4);
        press_digit(4'h0, 1);
        pulse_reset();
`endif

        // Random sessions: mix of correct and random codes, random gaps and idles.
        for (int s = 0; s < 40; s++) begin
            if ($urandom_range(0, 1) == 1)
                for (int i = 0; i < NDIG; i++) code_w[(NDIG-1-i)*4 +: 4] = m_code[i];
            else
                code_w = 16'($urandom);
            prog_btn = ($urandom_range(0, 7) == 0);
            enter_code(code_w);
            tick($urandom_range(0, 1) == 1 ? $urandom_range(0, 15) : $urandom_range(0, 40));
            prog_btn = 1'b0;
            if ($urandom_range(0, 9) == 0) tick(300);
        end

        tick(2);
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
